// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter. The head byte is offered on tx_data/tx_ready
// and is popped on the rising edge of tx_done.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  output logic [7:0]        tx_data,
  output logic              tx_ready,
  input  logic              tx_done,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  // state  | meaning
  // S_IDLE | nothing offered, waiting for data
  // S_SEND | head byte offered, waiting for tx_done rising edge
  // S_HOLD | byte popped, waiting for tx_done to drop
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [ADDR_W:0]   count;
  logic              done_d;
  logic              pop, push;
  state_t            state, state_next;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign level   = count;
  assign tx_data = mem[rd_ptr];

  assign pop  = (state == S_SEND) && tx_done && !done_d;
  assign push = wr_en && (!full || pop);

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE: state_next = (count != '0) ? S_SEND : S_IDLE;
      S_SEND: state_next = pop ? S_HOLD : S_SEND;
      S_HOLD: begin
        if (tx_done) state_next = S_HOLD;
        else         state_next = (count != '0) ? S_SEND : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      state    <= S_IDLE;
      tx_ready <= 1'b0;
      overflow <= 1'b0;
      done_d   <= 1'b0;
    end else begin
      done_d <= tx_done;
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        state    <= S_IDLE;
        tx_ready <= 1'b0;
        overflow <= 1'b0;
      end else begin
        state    <= state_next;
        tx_ready <= (state_next == S_SEND);
        if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
        if (push && !pop)      count <= count + (ADDR_W+1)'(1);
        else if (pop && !push) count <= count - (ADDR_W+1)'(1);
        if (wr_en && full && !pop) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table for single-byte/stream handshakes,
// plus hand sequences for overflow, full push+pop, flush and async reset.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .tx_data(tx_data), .tx_ready(tx_ready), .tx_done(tx_done),
    .full(full), .empty(empty), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       fl;
    logic       td;
    logic       rdy;
    logic [4:0] lvl;
    logic       ovf;
    logic       chkd;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(logic wr, logic [7:0] d, logic td, logic rdy,
                              logic [4:0] lvl, logic chkd, logic [7:0] dat);
    vec_t v;
    v.wr = wr; v.d = d; v.fl = 1'b0; v.td = td; v.rdy = rdy;
    v.lvl = lvl; v.ovf = 1'b0; v.chkd = chkd; v.dat = dat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait for the head byte to be offered, check it, then pulse tx_done for one cycle.
  task automatic send_byte(input logic [7:0] exp, input logic [4:0] lvl_after);
    bit seen = 0;
    @(negedge clk); tx_done = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (tx_ready) seen = 1;
    end
    chk("send_ready_timeout", {31'd0, seen}, 32'd1);
    chk("send_data", {24'd0, tx_data}, {24'd0, exp});
    @(negedge clk); tx_done = 1'b1;
    @(posedge clk); #1;
    chk("send_level", {27'd0, level}, {27'd0, lvl_after});
    chk("send_ready_low", {31'd0, tx_ready}, 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk); wr_en = 1'b1; wr_data = b;
    @(posedge clk); #1;
    @(negedge clk); wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; tx_done = 1'b0;

    //                wr  data  td  rdy lvl  chkd dat
    vecs[0]  = mk(0, 8'h00, 0, 0, 5'd0, 0, 8'h00);
    vecs[1]  = mk(1, 8'h41, 0, 0, 5'd1, 1, 8'h41);
    vecs[2]  = mk(0, 8'h00, 0, 1, 5'd1, 1, 8'h41);
    vecs[3]  = mk(0, 8'h00, 1, 0, 5'd0, 0, 8'h00);
    vecs[4]  = mk(0, 8'h00, 1, 0, 5'd0, 0, 8'h00);
    vecs[5]  = mk(0, 8'h00, 0, 0, 5'd0, 0, 8'h00);
    vecs[6]  = mk(1, 8'h48, 0, 0, 5'd1, 1, 8'h48);
    vecs[7]  = mk(1, 8'h69, 0, 1, 5'd2, 1, 8'h48);
    vecs[8]  = mk(1, 8'h0A, 0, 1, 5'd3, 1, 8'h48);
    vecs[9]  = mk(0, 8'h00, 1, 0, 5'd2, 1, 8'h69);
    vecs[10] = mk(0, 8'h00, 0, 1, 5'd2, 1, 8'h69);
    vecs[11] = mk(0, 8'h00, 1, 0, 5'd1, 1, 8'h0A);
    vecs[12] = mk(0, 8'h00, 1, 0, 5'd1, 0, 8'h00);
    vecs[13] = mk(0, 8'h00, 0, 1, 5'd1, 1, 8'h0A);
    vecs[14] = mk(0, 8'h00, 1, 0, 5'd0, 0, 8'h00);
    vecs[15] = mk(0, 8'h00, 0, 0, 5'd0, 0, 8'h00);
    // stale tx_done already high when 0x55 is offered, then a stalled transmitter
    vecs[16] = mk(1, 8'h55, 1, 0, 5'd1, 1, 8'h55);
    vecs[17] = mk(0, 8'h00, 1, 1, 5'd1, 1, 8'h55);
    vecs[18] = mk(0, 8'h00, 1, 1, 5'd1, 1, 8'h55);
    vecs[19] = mk(0, 8'h00, 0, 1, 5'd1, 1, 8'h55);
    vecs[20] = mk(0, 8'h00, 1, 0, 5'd0, 0, 8'h00);
    vecs[21] = mk(0, 8'h00, 0, 0, 5'd0, 0, 8'h00);

    #12;
    chk("reset_ready", {31'd0, tx_ready}, 32'd0);
    chk("reset_level", {27'd0, level}, 32'd0);
    chk("reset_empty", {31'd0, empty}, 32'd1);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      wr_en = vecs[i].wr; wr_data = vecs[i].d; flush = vecs[i].fl; tx_done = vecs[i].td;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ready", i), {31'd0, tx_ready}, {31'd0, vecs[i].rdy});
      chk($sformatf("vec%0d_level", i), {27'd0, level}, {27'd0, vecs[i].lvl});
      chk($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, (vecs[i].lvl == 5'd0)});
      chk($sformatf("vec%0d_full", i), {31'd0, full}, 32'd0);
      chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
      if (vecs[i].chkd)
        chk($sformatf("vec%0d_data", i), {24'd0, tx_data}, {24'd0, vecs[i].dat});
    end
    @(negedge clk); wr_en = 1'b0; tx_done = 1'b0;

    // 17 pushes with transmitter stalled: last byte dropped
    for (int b = 0; b < 17; b++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'(b);
      @(posedge clk); #1;
      if (b == 15) chk("fill_full16", {31'd0, full}, 32'd1);
      if (b == 15) chk("fill_ovf_before", {31'd0, overflow}, 32'd0);
    end
    chk("ovf_level", {27'd0, level}, 32'd16);
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_head", {24'd0, tx_data}, 32'h00);
    chk("ovf_ready", {31'd0, tx_ready}, 32'd1);

    // push while full on the same cycle as the pop
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hAA; tx_done = 1'b1;
    @(posedge clk); #1;
    chk("pushpop_level", {27'd0, level}, 32'd16);
    chk("pushpop_ovf", {31'd0, overflow}, 32'd1);
    @(negedge clk); wr_en = 1'b0;
    for (int b = 1; b < 16; b++) send_byte(8'(b), 5'(16 - b));
    send_byte(8'hAA, 5'd0);
    @(negedge clk); tx_done = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("drain_idle_ready", {31'd0, tx_ready}, 32'd0);
    chk("drain_ovf_sticky", {31'd0, overflow}, 32'd1);

    // flush mid-stream, with a push on the same cycle
    for (int b = 0; b < 5; b++) push_byte(8'h60 + 8'(b));
    @(negedge clk); flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77; tx_done = 1'b1;
    @(posedge clk); #1;
    chk("flush_level", {27'd0, level}, 32'd0);
    chk("flush_ready", {31'd0, tx_ready}, 32'd0);
    chk("flush_ovf", {31'd0, overflow}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    @(negedge clk); flush = 1'b0; wr_en = 1'b0; tx_done = 1'b0;
    push_byte(8'h31);
    send_byte(8'h31, 5'd0);
    @(negedge clk); tx_done = 1'b0;

    // async reset mid-frame with bytes queued and overflow set
    for (int b = 0; b < 18; b++) push_byte(8'h80 + 8'(b));
    chk("prerst_ovf", {31'd0, overflow}, 32'd1);
    chk("prerst_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("arst_level", {27'd0, level}, 32'd0);
    chk("arst_ready", {31'd0, tx_ready}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("postrst_ready", {31'd0, tx_ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
